// File: rtl/decodificador_mes_bcd.sv
// decodificador_mes_bcd
// Receive side of the month data path: takes a 2-digit BCD month byte
// (8'h01..8'h12), validates it and converts it to the binary month index
// 0..11 (January = 0) consumed by the month up/down counter.
// Request/ready handshake, 4-cycle sequence IDLE -> CHECK -> CONV -> DONE,
// one-cycle done pulse and mutually exclusive error flags.
// Optional build macro: DECOD_MES_SATURA_EN -- out-of-range BCD-legal values
// saturate to the nearest legal index instead of leaving mes_idx untouched.
module decodificador_mes_bcd #(
    parameter int unsigned MES_MIN = 1,
    parameter int unsigned MES_MAX = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_MES_in,
    input  logic       load_req,
    output logic       ready,
    output logic [3:0] mes_idx,
    output logic       mes_valid,
    output logic       done,
    output logic       err_bcd,
    output logic       err_rango
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_CONV,
        ST_DONE
    } estado_t;

    localparam logic [6:0] MIN_B = 7'(MES_MIN);
    localparam logic [6:0] MAX_B = 7'(MES_MAX);

    estado_t    state_q;
    logic [7:0] dato_q;
    logic       chk_err_bcd_q;
    logic [6:0] bin_q;

    logic       ready_q;
    logic [3:0] mes_idx_q;
    logic       mes_valid_q;
    logic       done_q;
    logic       err_bcd_q;
    logic       err_rango_q;

    // Digit split of the captured byte.
    logic [3:0] decenas;
    logic [3:0] unidades;
    assign decenas  = dato_q[7:4];
    assign unidades = dato_q[3:0];

    // CHECK-stage results: digit legality and tens*10 + units built from shifts.
    logic       err_bcd_d;
    logic [6:0] decenas_ext;
    logic [6:0] bin_d;
    assign err_bcd_d   = (decenas > 4'd9) | (unidades > 4'd9);
    assign decenas_ext = {3'b000, decenas};
    assign bin_d       = (decenas_ext << 3) + (decenas_ext << 1) + {3'b000, unidades};

    // CONV-stage results: range check and index, only meaningful without a BCD error.
    logic       fuera_rango;
    logic       err_rango_d;
    logic [3:0] idx_d;
    assign fuera_rango = (bin_q < MIN_B) | (bin_q > MAX_B);
    assign err_rango_d = !chk_err_bcd_q & fuera_rango;
    assign idx_d       = 4'(bin_q - MIN_B);

`ifdef DECOD_MES_SATURA_EN
    localparam logic [3:0] IDX_SAT_MAX = 4'(MES_MAX - MES_MIN);
    logic [3:0] idx_sat;
    assign idx_sat = (bin_q < MIN_B) ? 4'd0 : IDX_SAT_MAX;
`endif

    // Sequencer: capture, check, convert, publish; all outputs registered here.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: the captured byte and intermediates are reset too, so an
            // aborted request leaves no stale data behind and lint sees no X source.
            state_q       <= ST_IDLE;
            dato_q        <= '0;
            chk_err_bcd_q <= 1'b0;
            bin_q         <= '0;
            ready_q       <= 1'b1;
            mes_idx_q     <= '0;
            mes_valid_q   <= 1'b0;
            done_q        <= 1'b0;
            err_bcd_q     <= 1'b0;
            err_rango_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // samples the values from before this edge regardless of order.
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (load_req) begin
                        dato_q  <= data_MES_in;
                        ready_q <= 1'b0;
                        state_q <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    chk_err_bcd_q <= err_bcd_d;
                    bin_q         <= err_bcd_d ? 7'd0 : bin_d;
                    state_q       <= ST_CONV;
                end
                ST_CONV: begin
                    done_q      <= 1'b1;
                    err_bcd_q   <= chk_err_bcd_q;
                    err_rango_q <= err_rango_d;
                    if (!chk_err_bcd_q && !fuera_rango) begin
                        mes_idx_q   <= idx_d;
                        mes_valid_q <= 1'b1;
                    end
`ifdef DECOD_MES_SATURA_EN
                    else if (err_rango_d) begin
                        mes_idx_q   <= idx_sat;
                        mes_valid_q <= 1'b1;
                    end
`endif
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                // NOTE: explicit default keeps the case full; a clocked block
                // cannot infer latches, but this recovers from any illegal code.
                default: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready     = ready_q;
    assign mes_idx   = mes_idx_q;
    assign mes_valid = mes_valid_q;
    assign done      = done_q;
    assign err_bcd   = err_bcd_q;
    assign err_rango = err_rango_q;

endmodule

// File: tb/tb_decodificador_mes_bcd.sv
// Testbench for decodificador_mes_bcd: directed requests, a cycle-level
// reference model derived from the month rules, and literal expectations.
module tb_decodificador_mes_bcd;

    localparam int MIN_M = 1;
    localparam int MAX_M = 12;

    logic       clk;
    logic       reset;
    logic [7:0] data_MES_in;
    logic       load_req;
    logic       ready;
    logic [3:0] mes_idx;
    logic       mes_valid;
    logic       done;
    logic       err_bcd;
    logic       err_rango;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;

    decodificador_mes_bcd #(
        .MES_MIN(MIN_M),
        .MES_MAX(MAX_M)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data_MES_in(data_MES_in),
        .load_req   (load_req),
        .ready      (ready),
        .mes_idx    (mes_idx),
        .mes_valid  (mes_valid),
        .done       (done),
        .err_bcd    (err_bcd),
        .err_rango  (err_rango)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       eb;
        logic       er;
        logic       upd;
        logic [3:0] idx;
    } dec_t;

    // Decode a month byte from the decimal rules.
    function automatic dec_t model_decode(input logic [7:0] b);
        dec_t r;
        int t, u, v;
        t = int'(b[7:4]);
        u = int'(b[3:0]);
        r = '0;
        if (t > 9 || u > 9) begin
            r.eb = 1'b1;
        end else begin
            v = t * 10 + u;
            if (v < MIN_M || v > MAX_M) begin
                r.er = 1'b1;
`ifdef DECOD_MES_SATURA_EN
                r.upd = 1'b1;
                r.idx = (v < MIN_M) ? 4'd0 : 4'(MAX_M - MIN_M);
`endif
            end else begin
                r.upd = 1'b1;
                r.idx = 4'(v - MIN_M);
            end
        end
        return r;
    endfunction

    bit         model_ok = 1'b0;
    int         m_cnt;      // cycles elapsed since the accepting edge, 0 = idle
    logic [7:0] m_byte;
    logic       m_ready, m_done, m_valid, m_eb, m_er;
    logic [3:0] m_idx;
    dec_t       m_res;
    assign m_res = model_decode(m_byte);

    // Model advances on the same edges as the design.
    always @(posedge clk) begin
        if (!reset) begin
            model_ok <= 1'b1;
            m_cnt    <= 0;
            m_byte   <= 8'h00;
            m_ready  <= 1'b1;
            m_done   <= 1'b0;
            m_valid  <= 1'b0;
            m_eb     <= 1'b0;
            m_er     <= 1'b0;
            m_idx    <= 4'd0;
        end else if (model_ok) begin
            if (m_cnt == 0) begin
                m_done <= 1'b0;
                if (load_req) begin
                    m_byte  <= data_MES_in;
                    m_ready <= 1'b0;
                    m_cnt   <= 1;
                end
            end else if (m_cnt == 1) begin
                m_cnt <= 2;
            end else if (m_cnt == 2) begin
                m_done <= 1'b1;
                m_eb   <= m_res.eb;
                m_er   <= m_res.er;
                if (m_res.upd) begin
                    m_idx   <= m_res.idx;
                    m_valid <= 1'b1;
                end
                m_cnt <= 3;
            end else begin
                m_done  <= 1'b0;
                m_ready <= 1'b1;
                m_cnt   <= 0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_ok)
            check("model_cycle",
                  {7'd0, ready, done, mes_valid, err_bcd, err_rango, mes_idx},
                  {7'd0, m_ready, m_done, m_valid, m_eb, m_er, m_idx});
        if (done === 1'b1) done_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Issue one request and check the done pulse lands 3 cycles after acceptance.
    task automatic send(input logic [7:0] b);
        int w;
        w = 0;
        while (ready !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        check("ready_wait", {15'd0, ready}, 16'd1);
        data_MES_in = b;
        load_req    = 1'b1;
        tick();                       // accepting edge
        load_req = 1'b0;
        repeat (2) tick();
        check("done_latency", {15'd0, done}, 16'd1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    int d0;

    initial begin
        reset       = 1'b0;
        load_req    = 1'b0;
        data_MES_in = 8'h00;

        // Reset held for two edges.
        repeat (2) tick();
        reset = 1'b1;
        check("rst_ready", {15'd0, ready}, 16'd1);
        check("rst_idx", {12'd0, mes_idx}, 16'd0);
        check("rst_valid", {15'd0, mes_valid}, 16'd0);
        check("rst_done", {15'd0, done}, 16'd0);
        check("rst_flags", {14'd0, err_bcd, err_rango}, 16'd0);
        tick();

        // Single request 8'h07 with cycle-by-cycle handshake view.
        data_MES_in = 8'h07;
        load_req    = 1'b1;
        tick();                       // edge N
        load_req    = 1'b0;
        data_MES_in = 8'hFF;          // late change must not matter
        check("n1_ready_done", {14'd0, ready, done}, 16'd0);
        tick();
        check("n2_ready_done", {14'd0, ready, done}, 16'd0);
        tick();
        check("n3_ready_done", {14'd0, ready, done}, 16'd1);
        check("h07_idx", {12'd0, mes_idx}, 16'd6);
        check("h07_valid", {15'd0, mes_valid}, 16'd1);
        check("h07_flags", {14'd0, err_bcd, err_rango}, 16'd0);
        tick();
        check("n4_ready_done", {14'd0, ready, done}, 16'd2);

        // Legal sequence with one done each.
        d0 = done_cnt;
        send(8'h12);
        check("h12_idx", {12'd0, mes_idx}, 16'd11);
        send(8'h01);
        check("h01_idx", {12'd0, mes_idx}, 16'd0);
        send(8'h10);
        check("h10_idx", {12'd0, mes_idx}, 16'd9);
        check("seq_dones", 16'(done_cnt - d0), 16'd3);

        // Error cases after mes_idx = 4.
        send(8'h05);
        check("h05_idx", {12'd0, mes_idx}, 16'd4);
        send(8'h1A);
        check("h1A_flags", {14'd0, err_bcd, err_rango}, 16'b10);
        check("h1A_idx", {12'd0, mes_idx}, 16'd4);
        send(8'h13);
        check("h13_flags", {14'd0, err_bcd, err_rango}, 16'b01);
`ifdef DECOD_MES_SATURA_EN
        check("h13_idx", {12'd0, mes_idx}, 16'd11);
`else
        check("h13_idx", {12'd0, mes_idx}, 16'd4);
`endif
        send(8'h00);
        check("h00_flags", {14'd0, err_bcd, err_rango}, 16'b01);
`ifdef DECOD_MES_SATURA_EN
        check("h00_idx", {12'd0, mes_idx}, 16'd0);
`else
        check("h00_idx", {12'd0, mes_idx}, 16'd4);
`endif
        send(8'h0A);
        check("h0A_flags", {14'd0, err_bcd, err_rango}, 16'b10);
        send(8'hA1);
        check("hA1_flags", {14'd0, err_bcd, err_rango}, 16'b10);
        send(8'h99);
        check("h99_flags", {14'd0, err_bcd, err_rango}, 16'b01);
`ifdef DECOD_MES_SATURA_EN
        check("h99_idx", {12'd0, mes_idx}, 16'd11);
`else
        check("h99_idx", {12'd0, mes_idx}, 16'd4);
`endif

        // Request while busy is dropped.
        d0 = done_cnt;
        data_MES_in = 8'h05;
        load_req    = 1'b1;
        tick();                       // edge N accepts 8'h05
        data_MES_in = 8'h09;          // pulse during N+1, must be ignored
        tick();
        load_req = 1'b0;
        repeat (8) tick();
        check("busy_idx", {12'd0, mes_idx}, 16'd4);
        check("busy_dones", 16'(done_cnt - d0), 16'd1);
        check("busy_flags", {14'd0, err_bcd, err_rango}, 16'd0);

        // load_req held high: one request every 4 cycles.
        d0 = done_cnt;
        data_MES_in = 8'h03;
        load_req    = 1'b1;
        repeat (8) tick();
        load_req = 1'b0;
        repeat (6) tick();
        check("b2b_dones", 16'(done_cnt - d0), 16'd2);
        check("b2b_idx", {12'd0, mes_idx}, 16'd2);

        // Reset in the middle of a request.
        d0 = done_cnt;
        data_MES_in = 8'h08;
        load_req    = 1'b1;
        tick();                       // edge N accepts 8'h08
        load_req = 1'b0;
        tick();                       // cycle N+2
        reset = 1'b0;
        tick();                       // reset sampled at edge N+2
        reset = 1'b1;
        check("abort_idx", {12'd0, mes_idx}, 16'd0);
        check("abort_valid", {15'd0, mes_valid}, 16'd0);
        check("abort_flags", {13'd0, done, err_bcd, err_rango}, 16'd0);
        tick();
        check("abort_ready", {15'd0, ready}, 16'd1);
        repeat (5) tick();
        check("abort_dones", 16'(done_cnt - d0), 16'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
